// File: rtl/weight_dump_writer.sv
// Dumps the trained weight array into block RAM, saturating each word to WW bits.
// Define WDUMP_CHECKSUM_EN to append a mod-2^WW checksum word at address N.
module weight_dump_writer #(
  parameter int N  = 784,
  parameter int AW = 10,
  parameter int IW = 16,
  parameter int WW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        rd_addr,
  input  logic signed [IW-1:0] rd_data,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [WW-1:0]        wr_data,
  input  logic                 wr_ready,
  output logic [AW-1:0]        sat_count
);

`ifdef WDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_WRITE, S_DONE
  } state_t;
`endif

  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic signed [IW-1:0] SAT_HI =
    IW'((2 ** (WW - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_LO =
    IW'(-(2 ** (WW - 1)));
  localparam logic [WW-1:0] W_HI = {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0] W_LO = {1'b1, {(WW-1){1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [AW-1:0] sat_q, sat_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [WW-1:0] wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef WDUMP_CHECKSUM_EN
  logic [WW-1:0] sum_q, sum_d;
`endif

  logic [WW-1:0] sat_w;
  logic          clamp;

  always_comb begin
    sat_w = rd_data[WW-1:0];
    clamp = 1'b0;
    if (rd_data > SAT_HI) begin
      sat_w = W_HI;
      clamp = 1'b1;
    end else if (rd_data < SAT_LO) begin
      sat_w = W_LO;
      clamp = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    sat_d     = sat_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = wr_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef WDUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = '0;
          sat_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
`ifdef WDUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_FETCH: begin
        wr_data_d = sat_w;
        wr_addr_d = index_q;
        wr_en_d   = 1'b1;
        state_d   = S_WRITE;
        if (clamp) sat_d = sat_q + AW'(1);
      end
      S_WRITE: begin
        if (wr_ready) begin
`ifdef WDUMP_CHECKSUM_EN
          sum_d = sum_q + wr_data_q;
`endif
          if (index_q == LAST) begin
`ifdef WDUMP_CHECKSUM_EN
            wr_addr_d = AW'(N);
            wr_data_d = sum_d;
            state_d   = S_CSUM;
`else
            wr_en_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
`endif
          end else begin
            index_d = index_q + AW'(1);
            wr_en_d = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
`ifdef WDUMP_CHECKSUM_EN
      S_CSUM: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      sat_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WDUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      sat_q     <= sat_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef WDUMP_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // index only moves on entry to FETCH, so it doubles as the held read address
  assign rd_addr   = index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_weight_dump_writer.sv
// Randomized bench for weight_dump_writer against a queue-of-expected-writes model.
module tb_weight_dump_writer;
  localparam int N  = 784;
  localparam int AW = 10;
  localparam int IW = 16;
  localparam int WW = 12;
`ifdef WDUMP_CHECKSUM_EN
  localparam int LAT = 1569;
`else
  localparam int LAT = 1568;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic wr_ready = 1'b0;
  logic busy, done, wr_en;
  logic [AW-1:0] rd_addr, wr_addr, sat_count;
  logic signed [IW-1:0] rd_data;
  logic [WW-1:0] wr_data;

  logic signed [IW-1:0] wmem [0:(1<<AW)-1];
  logic [WW-1:0] exp_w [0:N];
  int exp_n = N;
  int exp_sat = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rdy_pct = 100;
  logic stall_q = 1'b0;
  logic done_prev = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [WW-1:0] hold_data;

  weight_dump_writer #(.N(N), .AW(AW), .IW(IW), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .sat_count(sat_count)
  );

  assign rd_data = wmem[rd_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 wr_ready = ($urandom_range(99) < rdy_pct);
  end

  // every accepted write must be the next entry of the expected image
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_wr_en", wr_en, 1);
        chk("stall_addr", wr_addr, hold_addr);
        chk("stall_data", wr_data, hold_data);
      end
      if (wr_en && wr_ready) begin
        if (wr_cnt >= exp_n) begin
          chk("extra_write_addr", wr_addr, exp_n - 1);
        end else begin
          chk("wr_addr", wr_addr, wr_cnt);
          chk("wr_data", wr_data, exp_w[wr_cnt]);
          chk("busy_in_write", busy, 1);
        end
        wr_cnt++;
      end
      stall_q = wr_en && !wr_ready;
      hold_addr = wr_addr;
      hold_data = wr_data;
      if (done) begin
        chk("writes_before_done", wr_cnt, exp_n);
        chk("done_width", done_prev, 0);
      end
      done_prev = done;
    end
  end

  task automatic load(input int mode);
    int v, s, sum;
    exp_sat = 0;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: wmem[i] = IW'(i);
        1: wmem[i] = (i == 0) ? 16'sd3000 :
                     (i == 1) ? -16'sd5000 :
                     (i == 2) ? 16'sd2047 :
                     (i == 3) ? -16'sd2048 : 16'sd0;
        default: wmem[i] = IW'($urandom);
      endcase
      v = int'(wmem[i]);
      s = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
      if (s != v) exp_sat++;
      exp_w[i] = s[WW-1:0];
      sum += s;
    end
    exp_n = N;
`ifdef WDUMP_CHECKSUM_EN
    exp_w[N] = sum[WW-1:0];
    exp_n = N + 1;
`endif
  endtask

  task automatic run(input int mode, input int pct,
                     input bit poke, input bit start_on_done);
    int st, dcyc;
    bit got;
    load(mode);
    rdy_pct = pct;
    wr_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    st = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    dcyc = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (poke && k == 200) start = 1'b1;
      if (poke && k == 201) start = 1'b0;
      if (done) begin
        got = 1;
        dcyc = cyc;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (pct == 100) chk("latency", dcyc - st, LAT);
    if (start_on_done) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("start_on_done_busy", busy, 0);
        chk("start_on_done_wr_en", wr_en, 0);
      end
    end else begin
      @(negedge clk);
      chk("busy_after_done", busy, 0);
    end
    chk("sat_count", sat_count, exp_sat);
    chk("write_count", wr_cnt, exp_n);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_sat_count", sat_count, 0);
  endtask

  initial begin
    bit hit;
    #1 rst_n = 1'b0;
    #2 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    load(0);
    chk("model_ramp_5", exp_w[5], 5);
`ifdef WDUMP_CHECKSUM_EN
    chk("model_csum", exp_w[N], 12'hEF8);
`endif
    run(0, 100, 0, 0);

    load(1);
    chk("model_sat0", exp_w[0], 12'h7FF);
    chk("model_sat1", exp_w[1], 12'h800);
    chk("model_sat_cnt", exp_sat, 2);
    run(1, 100, 0, 0);

    run(0, 50, 0, 0);
    run(2, 70, 0, 0);
    run(0, 100, 1, 1);
    run(0, 100, 0, 0);

    // reset in the middle of a dump, then a fresh dump from address 0
    load(0);
    rdy_pct = 100;
    wr_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (wr_cnt >= 400) begin
        hit = 1;
        break;
      end
    end
    chk("reached_write_400", hit, 1);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(0, 100, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
